// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/decode/control stage; owns the PC and the 32x32 register file, drives alu.
// Latency: 4 cycles per instruction (IF, ID, EX, WB); LW/SW add a MEM cycle for 5.
// Backpressure: none; memories answer in fixed time, and overflow/error/EOF park the FSM in HALT until reset.
module core_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_i_addr,
  input  logic [INST_W-1:0] i_i_inst,
  output logic              o_d_we,
  output logic [7:0]        o_d_addr,
  output logic [DATA_W-1:0] o_d_wdata,
  input  logic [DATA_W-1:0] i_d_rdata,
  output logic [2:0]        o_stt,
  output logic [5:0]        o_alu_op,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_im,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_ovflw,
  output logic [1:0]        o_status,
  output logic              o_status_valid
);

  localparam logic [5:0] OP_ADDI = 6'd5, OP_LW = 6'd6, OP_SW = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd11, OP_BNE = 6'd12, OP_EOF = 6'd14;
  localparam int AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
    S_MEM  = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, npc_q, npc_d, i_addr_q, i_addr_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [DATA_W-1:0]   res_q, res_d, ldata_q, ldata_d, wdata_q, wdata_d;
  logic [DATA_W-1:0]   data1_q, data1_d, data2_q, data2_d, im_q, im_d;
  logic [1:0]          status_q, status_d;
  logic [5:0]          alu_op_q, alu_op_d;
  logic [7:0]          d_addr_q, d_addr_d;
  logic                vld_q, vld_d, we_q, we_d;
  logic [DATA_W-1:0]   rf_q [32];
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  // Decode of the instruction arriving in ID and of the one held for EX/MEM/WB.
  logic [5:0]  id_op, ex_op;
  logic        ex_rtype, ex_mem, ex_wr, ex_illegal, ex_arith_ovf, ex_addr_err, ex_taken, ex_pc_err;
  logic [AW1-1:0] ex_npc;
  logic [1:0]  ex_status;

  assign id_op    = i_i_inst[31:26];
  assign ex_op    = inst_q[31:26];
  assign ex_rtype = ex_op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd13};
  assign ex_mem   = (ex_op == OP_LW) || (ex_op == OP_SW);
  assign ex_wr    = ex_rtype || (ex_op == OP_ADDI) || (ex_op == OP_LW);

  // EX-stage status resolution: branch compare, next PC and error detection.
  always_comb begin
    ex_illegal   = (ex_op == 6'd0) || (ex_op > OP_EOF);
    ex_arith_ovf = (ex_op >= 6'd1) && (ex_op <= 6'd5) && i_alu_ovflw;
    ex_addr_err  = ex_mem && ((i_alu_result >= DATA_W'(DMEM_WORDS)) || i_alu_ovflw);
    ex_taken     = ((ex_op == OP_BEQ) && (data1_q == data2_q)) ||
                   ((ex_op == OP_BNE) && (data1_q != data2_q));
    ex_npc       = {1'b0, pc_q} + AW1'(4) + (ex_taken ? AW1'(inst_q[15:0]) : '0);
    ex_pc_err    = ex_npc[ADDR_W] || (ex_npc >= AW1'(4 * IMEM_WORDS));
    if (ex_op == OP_EOF)
      ex_status = 2'd3;
    else if (ex_illegal || ex_arith_ovf || ex_addr_err || ex_pc_err)
      ex_status = 2'd2;
    else if (ex_rtype)
      ex_status = 2'd0;
    else
      ex_status = 2'd1;
  end

  // Next-state logic for the sequencer and every registered output.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    inst_d   = inst_q;
    res_d    = res_q;
    ldata_d  = ldata_q;
    wdata_d  = wdata_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    im_d     = im_q;
    status_d = status_q;
    alu_op_d = alu_op_q;
    d_addr_d = d_addr_q;
    vld_d    = 1'b0;
    we_d     = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        inst_d   = i_i_inst;
        alu_op_d = ((id_op == OP_LW) || (id_op == OP_SW)) ? OP_ADDI : id_op;
        data1_d  = rf_q[i_i_inst[25:21]];
        data2_d  = rf_q[i_i_inst[20:16]];
        im_d     = DATA_W'(i_i_inst[15:0]);
        state_d  = S_EX;
      end
      S_EX: begin
        res_d    = i_alu_result;
        npc_d    = ex_npc[ADDR_W-1:0];
        status_d = ex_status;
        if (ex_mem && !ex_addr_err) begin
          state_d  = S_MEM;
          d_addr_d = i_alu_result[7:0];
          wdata_d  = data2_q;
          we_d     = (ex_op == OP_SW);
        end else begin
          state_d = S_WB;
          vld_d   = 1'b1;
        end
      end
      S_MEM: begin
        ldata_d = i_d_rdata;
        state_d = S_WB;
        vld_d   = 1'b1;
      end
      S_WB: begin
        if (!status_q[1]) begin
          rf_we    = ex_wr;
          rf_waddr = ex_rtype ? inst_q[15:11] : inst_q[20:16];
          rf_wdata = (ex_op == OP_LW) ? ldata_q : res_q;
          pc_d     = npc_q;
          state_d  = S_IF;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    i_addr_d = pc_d;
  end

  // State, pipeline latches, outputs and register file.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      npc_q    <= '0;
      i_addr_q <= '0;
      inst_q   <= '0;
      res_q    <= '0;
      ldata_q  <= '0;
      wdata_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      im_q     <= '0;
      status_q <= '0;
      alu_op_q <= '0;
      d_addr_q <= '0;
      vld_q    <= 1'b0;
      we_q     <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      i_addr_q <= i_addr_d;
      inst_q   <= inst_d;
      res_q    <= res_d;
      ldata_q  <= ldata_d;
      wdata_q  <= wdata_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      im_q     <= im_d;
      status_q <= status_d;
      alu_op_q <= alu_op_d;
      d_addr_q <= d_addr_d;
      vld_q    <= vld_d;
      we_q     <= we_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign o_stt          = state_q;
  assign o_i_addr       = i_addr_q;
  assign o_d_we         = we_q;
  assign o_d_addr       = d_addr_q;
  assign o_d_wdata      = wdata_q;
  assign o_alu_op       = alu_op_q;
  assign o_data_1       = data1_q;
  assign o_data_2       = data2_q;
  assign o_im           = im_q;
  assign o_status       = status_q;
  assign o_status_valid = vld_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed programs run through core_ctrl with behavioural imem, dmem and alu models.
// Each scenario task loads a program, resets the core and checks status, latency and PC per instruction.
// Expected values are hand-derived from the instruction semantics.
module tb_core_ctrl;

  localparam logic [5:0] OP_ADD = 6'd1, OP_ADDU = 6'd3, OP_SUB = 6'd2, OP_SUBU = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5, OP_LW = 6'd6, OP_SW = 6'd7, OP_AND = 6'd8;
  localparam logic [5:0] OP_OR = 6'd9, OP_NOR = 6'd10, OP_BEQ = 6'd11, OP_BNE = 6'd12;
  localparam logic [5:0] OP_SLT = 6'd13, OP_EOF = 6'd14;
  localparam logic [31:0] EOF_W = {6'd14, 26'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] o_i_addr, i_i_inst, o_d_wdata, i_d_rdata, o_data_1, o_data_2, o_im;
  logic [31:0] i_alu_result;
  logic        o_d_we, i_alu_ovflw, o_status_valid;
  logic [7:0]  o_d_addr;
  logic [2:0]  o_stt;
  logic [5:0]  o_alu_op;
  logic [1:0]  o_status;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_i_addr(o_i_addr), .i_i_inst(i_i_inst),
    .o_d_we(o_d_we), .o_d_addr(o_d_addr), .o_d_wdata(o_d_wdata), .i_d_rdata(i_d_rdata),
    .o_stt(o_stt), .o_alu_op(o_alu_op), .o_data_1(o_data_1), .o_data_2(o_data_2),
    .o_im(o_im), .i_alu_result(i_alu_result), .i_alu_ovflw(i_alu_ovflw),
    .o_status(o_status), .o_status_valid(o_status_valid)
  );

  // Memories: synchronous instruction read, combinational data read, write on o_d_we.
  logic [31:0] imem [1024];
  logic [31:0] dmem [256];
  always @(posedge clk) i_i_inst <= imem[o_i_addr[11:2]];
  always @(posedge clk) if (o_d_we) dmem[o_d_addr] <= o_d_wdata;
  assign i_d_rdata = dmem[o_d_addr];

  // Reference alu behaviour.
  always_comb begin
    i_alu_result = '0;
    i_alu_ovflw  = 1'b0;
    case (o_alu_op)
      OP_ADD, OP_ADDU: begin
        i_alu_result = o_data_1 + o_data_2;
        i_alu_ovflw  = (o_alu_op == OP_ADD) && (o_data_1[31] == o_data_2[31]) &&
                       (i_alu_result[31] != o_data_1[31]);
      end
      OP_SUB, OP_SUBU: begin
        i_alu_result = o_data_1 - o_data_2;
        i_alu_ovflw  = (o_alu_op == OP_SUB) && (o_data_1[31] != o_data_2[31]) &&
                       (i_alu_result[31] != o_data_1[31]);
      end
      OP_ADDI: begin
        i_alu_result = o_data_1 + o_im;
        i_alu_ovflw  = (o_data_1[31] == o_im[31]) && (i_alu_result[31] != o_data_1[31]);
      end
      OP_AND: i_alu_result = o_data_1 & o_data_2;
      OP_OR:  i_alu_result = o_data_1 | o_data_2;
      OP_NOR: i_alu_result = ~(o_data_1 | o_data_2);
      OP_SLT: i_alu_result = {31'd0, $signed(o_data_1) < $signed(o_data_2)};
      default: i_alu_result = '0;
    endcase
  end

  // Observers: pulse counters and the PC seen during each IF.
  int          we_cnt = 0, vld_cnt = 0, mem_cnt = 0;
  logic [31:0] if_addr = '0, last_wd = '0;
  logic [7:0]  last_wa = '0;
  always @(negedge clk) begin
    if (o_d_we) begin we_cnt++; last_wa = o_d_addr; last_wd = o_d_wdata; end
    if (o_status_valid) vld_cnt++;
    if (o_stt == 3'd4) mem_cnt++;
    if (o_stt == 3'd1) if_addr = o_i_addr;
  end

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 1024; k++) imem[k] = EOF_W;
    for (int k = 0; k < 256; k++) dmem[k] = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the next o_status_valid pulse, returning the cycle count from the call.
  task automatic wait_vld(output int cyc, output logic [1:0] st);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_status_valid !== 1'b1 && cyc < 40);
    st = o_status;
    if (o_status_valid !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL status_valid_timeout: no pulse after %0d cycles, required within 40", cyc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_stt, o_d_we, o_status_valid, o_status, o_alu_op} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: stt=%0d we=%b vld=%b st=%0d op=%0d, required all 0",
               o_stt, o_d_we, o_status_valid, o_status, o_alu_op);
    end
    n_cmp++;
    if ({o_i_addr, o_d_addr, o_d_wdata, o_data_1, o_data_2, o_im} !== '0) begin
      n_err++;
      $display("FAIL reset_data: iaddr=%h daddr=%h wd=%h d1=%h d2=%h im=%h, required all 0",
               o_i_addr, o_d_addr, o_d_wdata, o_data_1, o_data_2, o_im);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_stt !== 3'd1) begin
      n_err++; $display("FAIL idle_to_if: stt=%0d, required 1", o_stt);
    end
  endtask

  task automatic test_add();
    int c, w0, v0;
    logic [1:0] s;
    int ep[5], ec[5], es[5];
    ep = '{0, 4, 8, 12, 16};
    ec = '{4, 4, 4, 5, 4};
    es = '{1, 1, 0, 1, 3};
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    imem[2] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    imem[3] = enc_i(OP_SW, 5'd0, 5'd3, 16'd0);
    reset_dut();
    w0 = we_cnt;
    for (int k = 0; k < 5; k++) begin
      wait_vld(c, s);
      n_cmp++;
      if (c !== ec[k] || s !== es[k] || if_addr !== ep[k]) begin
        n_err++;
        $display("FAIL add_step%0d: cyc=%0d st=%0d pc=%h, required cyc=%0d st=%0d pc=%h",
                 k, c, s, if_addr, ec[k], es[k], ep[k]);
      end
    end
    n_cmp++;
    if (we_cnt - w0 != 1 || last_wa !== 8'd0 || last_wd !== 32'd12) begin
      n_err++;
      $display("FAIL add_r3_store: pulses=%0d addr=%0d data=%0d, required 1 0 12",
               we_cnt - w0, last_wa, last_wd);
    end
    #1 v0 = vld_cnt;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (o_stt !== 3'd7 || vld_cnt != v0 || o_i_addr !== 32'h10) begin
      n_err++;
      $display("FAIL eof_halt: stt=%0d extra_vld=%0d pc=%h, required 7 0 10",
               o_stt, vld_cnt - v0, o_i_addr);
    end
  endtask

  task automatic test_overflow();
    int c, v0;
    logic [1:0] s, es;
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h7FFF);
    for (int k = 1; k <= 16; k++) imem[k] = enc_r(OP_ADDU, 5'd1, 5'd1, 5'd1);
    imem[17] = enc_i(OP_ADDI, 5'd1, 5'd1, 16'hFFFF);
    imem[18] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
    imem[19] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      wait_vld(c, s);
      es = (k == 19) ? 2'd2 : ((k >= 1 && k <= 16) ? 2'd0 : 2'd1);
      n_cmp++;
      if (s !== es || if_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL ovf_step%0d: st=%0d pc=%h, required st=%0d pc=%h", k, s, if_addr, es, 4 * k);
      end
    end
    #1 v0 = vld_cnt;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (o_stt !== 3'd7 || vld_cnt != v0 || o_i_addr !== 32'h4C) begin
      n_err++;
      $display("FAIL ovf_halt: stt=%0d extra_vld=%0d pc=%h, required 7 0 4c",
               o_stt, vld_cnt - v0, o_i_addr);
    end
  endtask

  task automatic test_mem();
    int c, w0;
    logic [1:0] s;
    int ec[6], es[6];
    ec = '{4, 4, 5, 5, 5, 4};
    es = '{1, 1, 1, 1, 1, 3};
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'h1234);
    imem[2] = enc_i(OP_SW, 5'd1, 5'd2, 16'd3);
    imem[3] = enc_i(OP_LW, 5'd0, 5'd5, 16'd4);
    imem[4] = enc_i(OP_SW, 5'd0, 5'd5, 16'd9);
    reset_dut();
    w0 = we_cnt;
    for (int k = 0; k < 6; k++) begin
      wait_vld(c, s);
      n_cmp++;
      if (c !== ec[k] || s !== es[k] || if_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL mem_step%0d: cyc=%0d st=%0d pc=%h, required cyc=%0d st=%0d pc=%h",
                 k, c, s, if_addr, ec[k], es[k], 4 * k);
      end
      if (k == 2) begin
        n_cmp++;
        if (we_cnt - w0 != 1 || last_wa !== 8'd4 || last_wd !== 32'h1234) begin
          n_err++;
          $display("FAIL sw_pulse: pulses=%0d addr=%0d data=%h, required 1 4 1234",
                   we_cnt - w0, last_wa, last_wd);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (we_cnt - w0 != 2 || last_wa !== 8'd9 || last_wd !== 32'h1234) begin
          n_err++;
          $display("FAIL lw_value: pulses=%0d addr=%0d data=%h, required 2 9 1234",
                   we_cnt - w0, last_wa, last_wd);
        end
      end
    end
  endtask

  task automatic test_addr_err();
    int c, w0, m0;
    logic [1:0] s;
    int ec[3], es[3];
    ec = '{4, 5, 4};
    es = '{1, 1, 2};
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd250);
    imem[1] = enc_i(OP_LW, 5'd1, 5'd6, 16'd5);
    imem[2] = enc_i(OP_LW, 5'd1, 5'd6, 16'd10);
    reset_dut();
    w0 = we_cnt;
    m0 = mem_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_vld(c, s);
      n_cmp++;
      if (c !== ec[k] || s !== es[k]) begin
        n_err++;
        $display("FAIL aerr_step%0d: cyc=%0d st=%0d, required cyc=%0d st=%0d", k, c, s, ec[k], es[k]);
      end
    end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (we_cnt != w0 || mem_cnt - m0 != 1 || o_stt !== 3'd7) begin
      n_err++;
      $display("FAIL aerr_no_mem: we=%0d mem_cycles=%0d stt=%0d, required 0 1 7",
               we_cnt - w0, mem_cnt - m0, o_stt);
    end
  endtask

  task automatic test_branch();
    int c;
    logic [1:0] s;
    int ep[8], es[8];
    ep = '{'h0, 'h4, 'h8, 'hC, 'h10, 'h1C, 'h20, 'h28};
    es = '{1, 1, 1, 1, 1, 1, 1, 3};
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3);
    imem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd3);
    imem[2] = enc_i(OP_ADDI, 5'd0, 5'd7, 16'd0);
    imem[3] = enc_i(OP_ADDI, 5'd0, 5'd7, 16'd0);
    imem[4] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'd8);
    imem[7] = enc_i(OP_BNE, 5'd1, 5'd2, 16'd4);
    imem[8] = enc_i(OP_BNE, 5'd1, 5'd0, 16'd4);
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      wait_vld(c, s);
      n_cmp++;
      if (c !== 4 || s !== es[k] || if_addr !== ep[k]) begin
        n_err++;
        $display("FAIL br_step%0d: cyc=%0d st=%0d pc=%h, required cyc=4 st=%0d pc=%h",
                 k, c, s, if_addr, es[k], ep[k]);
      end
    end
  endtask

  task automatic test_pc_range();
    int c;
    logic [1:0] s;
    clear_mem();
    imem[0]    = enc_i(OP_BEQ, 5'd0, 5'd0, 16'h0FF8);
    imem[1023] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'd0);
    reset_dut();
    wait_vld(c, s);
    n_cmp++;
    if (s !== 2'd1) begin
      n_err++; $display("FAIL pc_last_ok: st=%0d, required 1", s);
    end
    wait_vld(c, s);
    n_cmp++;
    if (s !== 2'd2 || if_addr !== 32'hFFC) begin
      n_err++; $display("FAIL pc_overrun: st=%0d pc=%h, required 2 ffc", s, if_addr);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_stt !== 3'd7 || o_i_addr !== 32'hFFC) begin
      n_err++; $display("FAIL pc_overrun_halt: stt=%0d pc=%h, required 7 ffc", o_stt, o_i_addr);
    end
  endtask

  task automatic test_eof_illegal();
    int c;
    logic [1:0] s;
    clear_mem();
    reset_dut();
    wait_vld(c, s);
    n_cmp++;
    if (c !== 4 || s !== 2'd3 || if_addr !== 32'd0) begin
      n_err++; $display("FAIL eof_at_0: cyc=%0d st=%0d pc=%h, required 4 3 0", c, s, if_addr);
    end
    imem[0] = enc_i(6'd15, 5'd0, 5'd0, 16'd0);
    reset_dut();
    wait_vld(c, s);
    n_cmp++;
    if (c !== 4 || s !== 2'd2) begin
      n_err++; $display("FAIL illegal_op: cyc=%0d st=%0d, required 4 2", c, s);
    end
  endtask

  task automatic test_reset_mid();
    int c, w0;
    logic [1:0] s;
    clear_mem();
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd2);
    imem[1] = enc_i(OP_SW, 5'd0, 5'd1, 16'd7);
    reset_dut();
    wait_vld(c, s);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_stt !== 3'd3) begin
      n_err++; $display("FAIL mid_in_ex: stt=%0d, required 3", o_stt);
    end
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_stt !== 3'd0 || o_i_addr !== 32'd0 || o_d_we !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort: stt=%0d pc=%h we=%b, required 0 0 0", o_stt, o_i_addr, o_d_we);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (we_cnt != w0) begin
      n_err++; $display("FAIL mid_no_store: pulses=%0d, required 0", we_cnt - w0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_vld(c, s);
    n_cmp++;
    if (c !== 4 || s !== 2'd1 || if_addr !== 32'd0) begin
      n_err++; $display("FAIL mid_restart: cyc=%0d st=%0d pc=%h, required 4 1 0", c, s, if_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_mem();
    test_addr_err();
    test_branch();
    test_pc_range();
    test_eof_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
